veririsc_sequencer: RTL

- Phase sequencer and control decoder for the VeriRISC datapath.
- Steps through an 8-phase fetch/execute cycle. Drives the address multiplexor select (instruction address vs operand address), plus memory read/write, IR/AC/PC load, PC increment and data-bus enable.
- Extends the basic controller with a memory-ready stall and a sticky halt state, so the core can wait on slow memory and be restarted without reset.

---
 rtl/veririsc_pkg.sv | 48 ++++
 rtl/veririsc_ctrl_decode.sv | 33 +++
 rtl/veririsc_sequencer.sv | 70 +++++++
 3 files changed

// File: rtl/veririsc_pkg.sv
// veririsc_pkg: shared opcodes, sequencer state encodings, control bundle and ALU-op helper
package veririsc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [3:0] INST_ADDR  = 4'd0;
  localparam logic [3:0] INST_FETCH = 4'd1;
  localparam logic [3:0] INST_LOAD  = 4'd2;
  localparam logic [3:0] IDLE       = 4'd3;
  localparam logic [3:0] OP_ADDR    = 4'd4;
  localparam logic [3:0] OP_FETCH   = 4'd5;
  localparam logic [3:0] ALU_OP     = 4'd6;
  localparam logic [3:0] STORE      = 4'd7;
  localparam logic [3:0] HALTED     = 4'd8;

  typedef struct packed {
    logic       sel;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       ld_ac;
    logic       ld_pc;
    logic       inc_pc;
    logic       data_e;
    logic       halt;
    logic       halted;
    logic [2:0] phase;
  } ctrl_t;

  // Values presented while reset is held: address mux on PC, phase 0, nothing else active.
  localparam ctrl_t CTRL_RESET = '{
    sel: 1'b1, rd: 1'b0, wr: 1'b0, ld_ir: 1'b0, ld_ac: 1'b0, ld_pc: 1'b0,
    inc_pc: 1'b0, data_e: 1'b0, halt: 1'b0, halted: 1'b0, phase: 3'd0
  };

  // Opcodes that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input logic [2:0] op);
    return op == ADD || op == AND || op == XOR || op == LDA;
  endfunction

endpackage

// File: rtl/veririsc_ctrl_decode.sv
// veririsc_ctrl_decode: combinational decode of sequencer state, opcode and zero flag into control strobes
module veririsc_ctrl_decode
  import veririsc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl
);

  logic [2:0] p;
  logic       v;
  logic       alu;

  // Phases 0..7 decode from the low bits; any state with bit 3 set (HALTED or illegal) drives no phase strobes.
  always_comb begin
    p = state[2:0];
    v = !state[3];
    alu = is_aluop(opcode);
    ctrl.sel    = v && !p[2];
    ctrl.rd     = v && ((p != 3'd0 && !p[2]) || (p[2] && p != 3'd4 && alu));
    ctrl.ld_ir  = v && (p == 3'd2 || p == 3'd3);
    ctrl.inc_pc = v && (p == 3'd4 || (p == 3'd6 && opcode == SKZ && zero));
    ctrl.halt   = state == HALTED || (v && p == 3'd4 && opcode == HLT);
    ctrl.ld_ac  = v && p == 3'd7 && alu;
    ctrl.ld_pc  = v && (p == 3'd6 || p == 3'd7) && opcode == JMP;
    ctrl.data_e = v && (p == 3'd6 || p == 3'd7) && opcode == STO;
    ctrl.wr     = v && p == 3'd7 && opcode == STO;
    ctrl.halted = state == HALTED;
    ctrl.phase  = state == HALTED ? 3'd3 : p;
  end

endmodule

// File: rtl/veririsc_sequencer.sv
// veririsc_sequencer: 8-phase VeriRISC fetch/execute sequencer with memory-ready stall and sticky halt
module veririsc_sequencer
  import veririsc_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int OPCODE_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  input  logic                    run,
  output logic                    sel,
  output logic                    rd,
  output logic                    wr,
  output logic                    ld_ir,
  output logic                    ld_ac,
  output logic                    ld_pc,
  output logic                    inc_pc,
  output logic                    data_e,
  output logic                    halt,
  output logic [2:0]              phase,
  output logic                    halted
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic       stall;
  ctrl_t      dec;
  ctrl_t      out;

  veririsc_ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (dec)
  );

  // Fetch phases wait for memory; the operand fetch only waits when an operand is actually read.
  // Illegal encodings above HALTED recover to INST_ADDR.
  always_comb begin
    stall = USE_MEM_READY != 0 && !mem_ready &&
            (state == INST_FETCH || (state == OP_FETCH && is_aluop(opcode)));
    state_next = state == HALTED ? (run ? INST_ADDR : HALTED) :
                 state[3] ? INST_ADDR :
                 stall ? state :
                 (state == OP_ADDR && opcode == HLT) ? HALTED :
                 {1'b0, state[2:0] + 3'd1};
  end

  // State register; reset wins over run and mem_ready.
  always_ff @(posedge clk) begin
    if (rst) state <= INST_ADDR;
    else state <= state_next;
  end

  // Reset masks the decode so nothing from the interrupted instruction leaks out.
  always_comb begin
    out = rst ? CTRL_RESET : dec;
    {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, halted, phase} = out;
  end

  // Bus and PC conflicts must be impossible for every state/opcode pairing.
  always_ff @(posedge clk) begin
    assert (!(out.rd && out.wr));
    assert (!(out.ld_pc && out.inc_pc));
  end

endmodule
